// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types, defaults and Gray/binary helpers for gray_step_tracker
package gray_pkg;

    localparam int DEF_W             = 4;
    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 4;
    localparam int MAX_W             = 32;

    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Callers zero-extend to MAX_W and pass the live width; bits at or above w come back as 0.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g, input int w);
        logic [MAX_W-1:0] b;
        logic             acc;
        b   = '0;
        acc = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i < w) begin
                acc  = acc ^ g[i];
                b[i] = acc;
            end
        end
        return b;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b, input int w);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < w) m[i] = 1'b1;
        end
        return (b & m) ^ ((b & m) >> 1);
    endfunction

endpackage

// File: rtl/gray_in_sync.sv
// rtl/gray_in_sync.sv - synchroniser and stability filter producing a settled-new-code strobe
module gray_in_sync
    import gray_pkg::*;
#(
    parameter int W             = DEF_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] gray_in,
    input  logic [W-1:0] ref_code,
    input  logic         ref_valid,
    output logic [W-1:0] cand,
    output logic         settled_new
);

    localparam int            CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic [W-1:0]  sync_q [SYNC_STAGES];
    logic [W-1:0]  s;
    logic [CW-1:0] cnt;
    logic          settled;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            cand <= '0;
            cnt  <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            if (s != cand) begin
                cand <= s;
                cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign settled = (s == cand) && (cnt == CNT_MAX);

    // Before the first lock there is no reference, so any settled code (even 0) is new.
    assign settled_new = settled && (!ref_valid || (cand != ref_code));

endmodule

// File: rtl/gray_step_tracker.sv
// rtl/gray_step_tracker.sv - Gray step classifier with position and error counters
module gray_step_tracker
    import gray_pkg::*;
#(
    parameter int W             = DEF_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] gray_in,
    input  logic         clr,
    output logic [W-1:0] bin_out,
    output logic [7:0]   pos,
    output logic         dir,
    output logic         step_pulse,
    output logic         err_pulse,
    output logic [7:0]   err_cnt,
    output logic         locked
);

    state_t       state;
    logic [W-1:0] ref_q;
    logic [W-1:0] cand;
    logic         settled_new;
    logic [W-1:0] new_bin;
    logic [W-1:0] d;

    gray_in_sync #(
        .W             (W),
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .gray_in     (gray_in),
        .ref_code    (ref_q),
        .ref_valid   (state == TRACK),
        .cand        (cand),
        .settled_new (settled_new)
    );

    assign new_bin = W'(gray2bin(MAX_W'(cand), W));
    assign d       = new_bin - bin_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            ref_q      <= '0;
            bin_out    <= '0;
            pos        <= '0;
            dir        <= 1'b0;
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            locked     <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            if (settled_new) begin
                ref_q   <= cand;
                bin_out <= new_bin;
                if (state == INIT) begin
                    state  <= TRACK;
                    locked <= 1'b1;
                end else if (d == W'(1)) begin
                    dir <= 1'b1;
                    if (!clr) begin
                        step_pulse <= 1'b1;
                        pos        <= pos + 8'd1;
                    end
                end else if (d == {W{1'b1}}) begin
                    dir <= 1'b0;
                    if (!clr) begin
                        step_pulse <= 1'b1;
                        pos        <= pos - 8'd1;
                    end
                end else if (!clr) begin
                    err_pulse <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
            end
            // clr overrides whatever the acceptance above did to the counters.
            if (clr) begin
                pos     <= '0;
                err_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gray_step_tracker.sv
// tb/tb_gray_step_tracker.sv - directed table-driven bench for gray_step_tracker
module tb_gray_step_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] gray_in = 4'b0000;
    logic       clr = 1'b0;
    logic [3:0] bin_out;
    logic [7:0] pos;
    logic       dir;
    logic       step_pulse;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic       locked;

    int tests = 0;
    int fails = 0;
    int nstep = 0;
    int nerr  = 0;

    always #5 clk = ~clk;

    gray_step_tracker dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gray_in    (gray_in),
        .clr        (clr),
        .bin_out    (bin_out),
        .pos        (pos),
        .dir        (dir),
        .step_pulse (step_pulse),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .locked     (locked)
    );

    typedef struct {
        bit         rst;
        logic [3:0] gray;
        bit         clr;
        logic [3:0] bin;
        logic [7:0] pos;
        bit         dir;
        int         nstep;
        int         nerr;
        logic [7:0] ec;
        bit         lock;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            if (step_pulse) nstep++;
            if (err_pulse) nerr++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        nstep = 0;
        nerr  = 0;
        gray_in = v.gray;
        if (v.rst) do_reset();
        for (int k = 1; k <= 12; k++) begin
            if (k == 7 && v.clr) clr = 1'b1;
            hold(1);
            clr = 1'b0;
        end
        chk($sformatf("v%0d bin", idx), 32'(bin_out), 32'(v.bin));
        chk($sformatf("v%0d pos", idx), 32'(pos), 32'(v.pos));
        chk($sformatf("v%0d dir", idx), 32'(dir), 32'(v.dir));
        chk($sformatf("v%0d steps", idx), 32'(nstep), 32'(v.nstep));
        chk($sformatf("v%0d errs", idx), 32'(nerr), 32'(v.nerr));
        chk($sformatf("v%0d err_cnt", idx), 32'(err_cnt), 32'(v.ec));
        chk($sformatf("v%0d locked", idx), 32'(locked), 32'(v.lock));
    endtask

    initial begin
        logic [3:0] b;

        // rst, gray, clr, bin, pos, dir, nstep, nerr, err_cnt, locked
        vecs[0]  = '{1, 4'b0110, 0, 4'd4,  8'h00, 0, 0, 0, 8'h00, 1};
        vecs[1]  = '{1, 4'b0000, 0, 4'd0,  8'h00, 0, 0, 0, 8'h00, 1};
        vecs[2]  = '{0, 4'b0001, 0, 4'd1,  8'h01, 1, 1, 0, 8'h00, 1};
        vecs[3]  = '{0, 4'b0011, 0, 4'd2,  8'h02, 1, 1, 0, 8'h00, 1};
        vecs[4]  = '{1, 4'b0000, 0, 4'd0,  8'h00, 0, 0, 0, 8'h00, 1};
        vecs[5]  = '{0, 4'b1000, 0, 4'd15, 8'hFF, 0, 1, 0, 8'h00, 1};
        vecs[6]  = '{0, 4'b0000, 0, 4'd0,  8'h00, 1, 1, 0, 8'h00, 1};
        vecs[7]  = '{1, 4'b0001, 0, 4'd1,  8'h00, 0, 0, 0, 8'h00, 1};
        vecs[8]  = '{0, 4'b1001, 0, 4'd14, 8'h00, 0, 0, 1, 8'h01, 1};
        vecs[9]  = '{0, 4'b1011, 0, 4'd13, 8'hFF, 0, 1, 0, 8'h01, 1};
        vecs[10] = '{0, 4'b1011, 0, 4'd13, 8'hFF, 0, 0, 0, 8'h01, 1};
        vecs[11] = '{0, 4'b1100, 0, 4'd8,  8'hFF, 0, 0, 1, 8'h02, 1};
        vecs[12] = '{0, 4'b1101, 1, 4'd9,  8'h00, 1, 0, 0, 8'h00, 1};
        vecs[13] = '{0, 4'b1111, 0, 4'd10, 8'h01, 1, 1, 0, 8'h00, 1};

        // Reset values, then exact acceptance edge for the first lock.
        gray_in = 4'b0110;
        rst_n   = 1'b0;
        #1;
        chk("reset outputs", 32'({bin_out, pos, dir, step_pulse, err_pulse, err_cnt, locked}), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) tick();
        chk("edge6 locked", 32'(locked), 32'd0);
        tick();
        chk("edge7 locked", 32'(locked), 32'd1);
        chk("edge7 bin", 32'(bin_out), 32'd4);
        chk("edge7 pulses", 32'({step_pulse, err_pulse}), 32'd0);

        for (int i = 0; i < 14; i++) apply(vecs[i], i);

        // Reset asserted mid-cycle clears outputs without a clock edge, then relocks silently.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset", 32'({bin_out, pos, dir, step_pulse, err_pulse, err_cnt, locked}), 32'd0);
        tick();
        rst_n = 1'b1;
        nstep = 0;
        nerr  = 0;
        hold(12);
        chk("relock locked", 32'(locked), 32'd1);
        chk("relock bin", 32'(bin_out), 32'd10);
        chk("relock pulses", 32'(nstep + nerr), 32'd0);

        // A 3-sample glitch must be filtered out.
        gray_in = 4'b0000;
        do_reset();
        hold(10);
        nstep = 0;
        nerr  = 0;
        gray_in = 4'b0001;
        hold(3);
        gray_in = 4'b0000;
        hold(15);
        chk("glitch pulses", 32'(nstep + nerr), 32'd0);
        chk("glitch bin", 32'(bin_out), 32'd0);

        // 128 up steps wrap pos to -128, one down step back to 127.
        nstep = 0;
        nerr  = 0;
        for (int i = 1; i <= 128; i++) begin
            b = 4'(i);
            gray_in = b ^ (b >> 1);
            hold(9);
        end
        chk("wrap steps", 32'(nstep), 32'd128);
        chk("wrap pos", 32'(pos), 32'h80);
        b = 4'd15;
        gray_in = b ^ (b >> 1);
        hold(9);
        chk("unwrap pos", 32'(pos), 32'h7F);
        chk("unwrap dir", 32'(dir), 32'd0);

        // Error counter saturates at 255.
        gray_in = 4'b0000;
        do_reset();
        hold(10);
        nstep = 0;
        nerr  = 0;
        for (int i = 0; i < 257; i++) begin
            gray_in = (i % 2 == 0) ? 4'b1100 : 4'b0000;
            hold(9);
        end
        chk("sat errs", 32'(nerr), 32'd257);
        chk("sat err_cnt", 32'(err_cnt), 32'hFF);
        chk("sat pos", 32'(pos), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
